// File: rtl/map_tile_writer.sv
`default_nettype none
// ============================================================================
// Module      : map_tile_writer
// Description : Write side of the level map RAM. Queues head-bump events,
//               then read-modify-writes each bumped tile. A question block
//               becomes a used block, and a brick becomes sky. Each converted
//               tile produces one score pulse.
// Config      : BRICK_BREAK_EN - when defined, bricks are broken into sky.
//               When undefined, bricks are left untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module map_tile_writer #(
    parameter int MAP_W      = 212,
    parameter int FIFO_DEPTH = 4,
    parameter int BRICK_ID   = 1,
    parameter int QBLOCK_ID  = 2,
    parameter int USED_ID    = 3,
    parameter int SKY_ID     = 63,
    parameter int Q_SCORE    = 50,
    parameter int B_SCORE    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bump_valid,
    input  logic [4:0]  bump_row,
    input  logic [7:0]  bump_col,
    output logic        bump_ready,
    output logic [11:0] map_addr,
    input  logic [5:0]  map_rd_data,
    output logic        map_we,
    output logic [5:0]  map_wr_data,
    output logic [15:0] score_add,
    output logic        score_vld,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]       ROW_LIMIT  = 5'd13;
    localparam logic [7:0]       COL_LIMIT  = 8'(MAP_W);
    localparam logic [11:0]      ROW_STRIDE = 12'(MAP_W);
    localparam logic [5:0]       BRICK_T    = 6'(BRICK_ID);
    localparam logic [5:0]       QBLOCK_T   = 6'(QBLOCK_ID);
    localparam logic [5:0]       USED_T     = 6'(USED_ID);
    localparam logic [5:0]       SKY_T      = 6'(SKY_ID);
    localparam logic [15:0]      Q_PTS      = 16'(Q_SCORE);
    localparam logic [15:0]      B_PTS      = 16'(B_SCORE);
`ifdef BRICK_BREAK_EN
    localparam logic BRICK_EN = 1'b1;
`else
    localparam logic BRICK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WAIT   = 3'd2,
        S_DECIDE = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t state, state_next;

    // Event FIFO: {row, col} per entry
    logic [12:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic        in_range, full, empty, pop, push, drop;
    logic [12:0] head;
    logic [11:0] head_addr;
    logic        write_hit;
    logic [5:0]  wr_data_next;
    logic [15:0] score_next;

    assign in_range = (bump_row < ROW_LIMIT) && (bump_col < COL_LIMIT);
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop      = (state == S_IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign bump_ready = !full || pop;
    assign push     = bump_valid && bump_ready && in_range;
    assign drop     = bump_valid && (!bump_ready || !in_range);
    assign busy     = (state != S_IDLE) || !empty;

    assign head      = fifo_mem[rd_ptr];
    assign head_addr = ROW_STRIDE * {7'd0, head[12:8]} + {4'd0, head[7:0]};

    // FIFO storage; contents need no reset because count gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bump_row, bump_col};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of events discarded (FIFO full or off-map)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic and tile conversion decision
    always_comb begin
        state_next   = state;
        write_hit    = 1'b0;
        wr_data_next = '0;
        score_next   = '0;
        case (state)
            S_IDLE:   if (!empty) state_next = S_ADDR;
            S_ADDR:   state_next = S_WAIT;
            S_WAIT:   state_next = S_DECIDE;
            S_DECIDE: begin
                state_next = S_IDLE;
                if (map_rd_data == QBLOCK_T) begin
                    write_hit    = 1'b1;
                    wr_data_next = USED_T;
                    score_next   = Q_PTS;
                end else if (BRICK_EN && (map_rd_data == BRICK_T)) begin
                    write_hit    = 1'b1;
                    wr_data_next = SKY_T;
                    score_next   = B_PTS;
                end
                if (write_hit) state_next = S_WRITE;
            end
            S_WRITE:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Registered RAM port and score outputs; write lasts exactly the WRITE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            map_addr    <= '0;
            map_we      <= 1'b0;
            map_wr_data <= '0;
            score_add   <= '0;
            score_vld   <= 1'b0;
        end else begin
            if (pop) map_addr <= head_addr;
            map_we    <= write_hit;
            score_vld <= write_hit;
            score_add <= score_next;
            if (write_hit) map_wr_data <= wr_data_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_tile_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_tile_writer
// Description : Directed self-checking bench for map_tile_writer with a
//               behavioural 1-cycle-latency map RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_tile_writer;

    logic        clk;
    logic        rst;
    logic        bump_valid;
    logic [4:0]  bump_row;
    logic [7:0]  bump_col;
    logic        bump_ready;
    logic [11:0] map_addr;
    logic [5:0]  map_rd_data;
    logic        map_we;
    logic [5:0]  map_wr_data;
    logic [15:0] score_add;
    logic        score_vld;
    logic        busy;
    logic [7:0]  drop_cnt;

    map_tile_writer dut (
        .clk         (clk),
        .rst         (rst),
        .bump_valid  (bump_valid),
        .bump_row    (bump_row),
        .bump_col    (bump_col),
        .bump_ready  (bump_ready),
        .map_addr    (map_addr),
        .map_rd_data (map_rd_data),
        .map_we      (map_we),
        .map_wr_data (map_wr_data),
        .score_add   (score_add),
        .score_vld   (score_vld),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    logic [5:0]  ram [4096];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          we_cnt   = 0;
    int          vld_cnt  = 0;
    int          sync_err = 0;
    logic [11:0] wr_log [$];

    initial clk = 1'b0;
    // Clock generation
    always #5 clk = ~clk;

    // Behavioural map RAM: registered read, write on the clock edge
    always @(posedge clk) begin
        map_rd_data <= ram[map_addr];
        if (map_we) ram[map_addr] <= map_wr_data;
    end

    // Write/score monitor sampled mid-cycle
    always @(negedge clk) begin
        if (map_we) begin
            we_cnt = we_cnt + 1;
            wr_log.push_back(map_addr);
        end
        if (score_vld) vld_cnt = vld_cnt + 1;
        if (map_we != score_vld) sync_err = sync_err + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Called at a negedge; the event is captured at the following posedge
    task automatic bump(input int row, input int col);
        bump_valid = 1'b1;
        bump_row   = 5'(row);
        bump_col   = 8'(col);
        @(negedge clk);
        bump_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 60) begin
            @(negedge clk);
            k = k + 1;
        end
        check(tag, int'(k < 60), 1);
    endtask

    initial begin
        int base_we, base_vld, base_log;
        int exp_addr [6];
        exp_addr = '{212, 213, 214, 215, 216, 218};

        for (int i = 0; i < 4096; i++) ram[i] = 6'd0;
        ram[2170] = 6'd2;                       // (10,50) question block
        ram[1928] = 6'd1;                       // (9,20) brick
        for (int i = 212; i <= 218; i++) ram[i] = 6'd2;   // row 1 cols 0..6
        for (int i = 222; i <= 224; i++) ram[i] = 6'd2;   // row 1 cols 10..12

        rst = 1'b1; bump_valid = 1'b0; bump_row = '0; bump_col = '0;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", int'(bump_ready), 1);
        check("rst_addr", int'(map_addr), 0);
        check("rst_we", int'(map_we), 0);
        check("rst_wdata", int'(map_wr_data), 0);
        check("rst_score", int'(score_add), 0);
        check("rst_vld", int'(score_vld), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(drop_cnt), 0);
        rst = 1'b1;
        @(negedge clk);

        // Question block at (10,50): write 3 to 2170 exactly at N+4
        bump(10, 50);
        check("qb_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        check("qb_n3_we", int'(map_we), 0);
        @(negedge clk);
        check("qb_we", int'(map_we), 1);
        check("qb_addr", int'(map_addr), 2170);
        check("qb_wdata", int'(map_wr_data), 3);
        check("qb_vld", int'(score_vld), 1);
        check("qb_score", int'(score_add), 50);
        @(negedge clk);
        check("qb_we_off", int'(map_we), 0);
        wait_idle("qb_idle");
        check("qb_ram", int'(ram[2170]), 3);

        // Repeat bump reads the used block: no write, no score
        base_we = we_cnt; base_vld = vld_cnt;
        bump(10, 50);
        repeat (8) @(negedge clk);
        check("dup_we", we_cnt - base_we, 0);
        check("dup_vld", vld_cnt - base_vld, 0);
        wait_idle("dup_idle");

        // Brick at (9,20) -> addr 1928
        bump(9, 20);
        repeat (4) @(negedge clk);
`ifdef BRICK_BREAK_EN
        check("brk_we", int'(map_we), 1);
        check("brk_addr", int'(map_addr), 1928);
        check("brk_wdata", int'(map_wr_data), 63);
        check("brk_score", int'(score_add), 10);
        wait_idle("brk_idle");
        check("brk_ram", int'(ram[1928]), 63);
`else
        check("brk_we", int'(map_we), 0);
        check("brk_vld", int'(score_vld), 0);
        wait_idle("brk_idle");
        check("brk_ram", int'(ram[1928]), 1);
`endif

        // Off-map coordinates are dropped, never queued
        bump(13, 5);
        check("rng_row_drop", int'(drop_cnt), 1);
        check("rng_row_busy", int'(busy), 0);
        bump(2, 212);
        check("rng_col_drop", int'(drop_cnt), 2);
        check("rng_col_busy", int'(busy), 0);

        // Seven back-to-back bumps, cols 0..6 of row 1. Col 0 is popped at
        // once, cols 1..4 fill the FIFO, col 5 meets a full FIFO in the WRITE
        // cycle and is dropped, col 6 rides the IDLE pop into a full FIFO.
        base_log = wr_log.size();
        for (int i = 0; i < 7; i++) begin
            if (i == 5) check("burst_full_ready", int'(bump_ready), 0);
            if (i == 6) begin
                check("burst_drop", int'(drop_cnt), 3);
                check("burst_pop_ready", int'(bump_ready), 1);
            end
            bump_valid = 1'b1;
            bump_row   = 5'd1;
            bump_col   = 8'(i);
            @(negedge clk);
        end
        bump_valid = 1'b0;
        wait_idle("burst_idle");
        check("burst_nwr", wr_log.size() - base_log, 6);
        for (int i = 0; i < 6; i++) begin
            if (base_log + i < wr_log.size())
                check($sformatf("burst_order%0d", i), int'(wr_log[base_log + i]), exp_addr[i]);
        end
        check("burst_skip_ram", int'(ram[217]), 2);
        check("burst_ram218", int'(ram[218]), 3);

        // Reset while the FSM sits in WAIT with two events still queued
        bump_valid = 1'b1; bump_row = 5'd1; bump_col = 8'd10;
        @(negedge clk);
        bump_col = 8'd11;
        @(negedge clk);
        bump_col = 8'd12;
        @(negedge clk);
        check("mid_addr", int'(map_addr), 222);
        check("mid_busy", int'(busy), 1);
        bump_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_we", int'(map_we), 0);
        check("mid_rst_ready", int'(bump_ready), 1);
        check("mid_rst_drop", int'(drop_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        base_we = we_cnt; base_vld = vld_cnt;
        repeat (10) @(negedge clk);
        check("post_rst_we", we_cnt - base_we, 0);
        check("post_rst_vld", vld_cnt - base_vld, 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_ram222", int'(ram[222]), 2);
        check("post_rst_ram223", int'(ram[223]), 2);

        // Normal processing resumes after reset
        bump(1, 10);
        repeat (4) @(negedge clk);
        check("resume_we", int'(map_we), 1);
        check("resume_addr", int'(map_addr), 222);
        check("resume_wdata", int'(map_wr_data), 3);
        check("resume_vld", int'(score_vld), 1);
        wait_idle("resume_idle");
        check("we_vld_sync", sync_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
